cbus_burst_arbiter: RTL and testbench

//  Shares the single cbus memory port among NUM_REQ cache-side masters (ICache, DCache line fill/flush, uncached path).

---
 rtl/cbus_burst_arbiter.sv | 144 ++++++++++++++
 tb/tb_cbus_burst_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_burst_arbiter.sv
// cbus burst arbiter: shares one cbus memory port among NUM_REQ cache-side masters.
// A grant is taken in IDLE and held for a whole burst, until the memory side
// returns ready & last. Only the granted master sees the response.

// Shared cbus types, visible to every file compiled after this one.
typedef enum logic [3:0] {
  MLEN1  = 4'd0,
  MLEN2  = 4'd1,
  MLEN4  = 4'd3,
  MLEN8  = 4'd7,
  MLEN16 = 4'd15
} cbus_len_t;

typedef struct packed {
  logic        valid;
  logic        is_write;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [3:0]  strobe;
  logic [31:0] data;
  cbus_len_t   len;
} cbus_req_t;

typedef struct packed {
  logic        ready;
  logic        last;
  logic [31:0] data;
} cbus_resp_t;

module cbus_burst_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter bit          RR_EN   = 1'b1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  cbus_req_t  [NUM_REQ-1:0]          ireqs,
  output cbus_resp_t [NUM_REQ-1:0]          iresps,
  output cbus_req_t                         oreq,
  input  cbus_resp_t                        oresp,
  output logic                              busy,
  output logic [$clog2(NUM_REQ)-1:0]        grant_idx
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]   rr_q, rr_d;

  logic              any_valid;
  logic [IdxW-1:0]   winner;
  logic [IdxW-1:0]   scan_base;
  logic [IdxW-1:0]   cand;
  logic              burst_done;

  // Index arithmetic modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base,
                                               input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end
    return IdxW'(sum);
  endfunction

  assign burst_done = oresp.ready & oresp.last;

  // Winner selection: first valid index scanning upward from the base, with wrap.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    cand      = '0;
    scan_base = RR_EN ? rr_q : '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = wrap_add(scan_base, k);
      if (!any_valid && ireqs[cand].valid) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  // Next-state logic: grant in IDLE, release only on the final beat of the burst.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    unique case (state_q)
      StIdle: begin
        // Stray ready/last from the memory side is ignored here.
        if (any_valid) begin
          grant_d = winner;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (burst_done) begin
          state_d = StIdle;
          // The master just served drops to lowest priority.
          if (RR_EN) begin
            rr_d = wrap_add(grant_q, 1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, grant and round-robin pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // Datapath: pass the granted request down and its response back, zero otherwise.
  always_comb begin
    oreq   = '0;
    iresps = '0;
    if (state_q == StBusy) begin
      // Forwarded even if the master dropped valid mid-burst; the grant stays until last.
      oreq            = ireqs[grant_q];
      iresps[grant_q] = oresp;
    end
  end

  assign busy      = (state_q == StBusy);
  assign grant_idx = grant_q;

endmodule

// File: tb/tb_cbus_burst_arbiter.sv
// Directed bench for cbus_burst_arbiter: one round-robin and one fixed-priority
// instance share the same stimulus; each scenario checks the relevant instance.
module tb_cbus_burst_arbiter;

  localparam int unsigned N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  cbus_req_t  [N-1:0]    ireqs;
  cbus_resp_t            oresp;

  cbus_resp_t [N-1:0]    iresps_rr, iresps_fp;
  cbus_req_t             oreq_rr, oreq_fp;
  logic                  busy_rr, busy_fp;
  logic [0:0]            gidx_rr, gidx_fp;

  int errors = 0;
  int checks = 0;

  cbus_burst_arbiter #(.NUM_REQ(N), .RR_EN(1'b1)) u_dut_rr (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs),
    .iresps    (iresps_rr),
    .oreq      (oreq_rr),
    .oresp     (oresp),
    .busy      (busy_rr),
    .grant_idx (gidx_rr)
  );

  cbus_burst_arbiter #(.NUM_REQ(N), .RR_EN(1'b0)) u_dut_fp (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs),
    .iresps    (iresps_fp),
    .oreq      (oreq_fp),
    .oresp     (oresp),
    .busy      (busy_fp),
    .grant_idx (gidx_fp)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ireqs = '0;
    oresp = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  function automatic cbus_req_t mkreq(input logic wr, input logic [31:0] addr,
                                      input cbus_len_t len, input logic [31:0] data);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.size     = 3'd2;
    r.addr     = addr;
    r.strobe   = wr ? 4'hf : 4'h0;
    r.data     = data;
    r.len      = len;
    return r;
  endfunction

  function automatic cbus_resp_t mkresp(input logic last, input logic [31:0] data);
    cbus_resp_t r;
    r.ready = 1'b1;
    r.last  = last;
    r.data  = data;
    return r;
  endfunction

  // Watchdog: the scenarios are straight-line, but never let the run hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ready_cnt;
    int last_cnt;

    // ---- reset state ----
    do_reset();
    check("rst busy",   128'(busy_rr),   128'(0));
    check("rst gidx",   128'(gidx_rr),   128'(0));
    check("rst oreq",   128'(oreq_rr),   128'(0));
    check("rst iresps", 128'(iresps_rr), 128'(0));
    check("rst fp busy", 128'(busy_fp),  128'(0));

    // ---- 1: single DCache 16-beat read ----
    ireqs[1] = mkreq(1'b0, 32'h1000_0040, MLEN16, 32'h0);
    #1;
    check("t1 idle oreq", 128'(oreq_rr), 128'(0));
    check("t1 idle busy", 128'(busy_rr), 128'(0));
    tick();
    check("t1 busy",      128'(busy_rr), 128'(1));
    check("t1 gidx",      128'(gidx_rr), 128'(1));
    check("t1 oreq",      128'(oreq_rr), 128'(ireqs[1]));
    ready_cnt = 0;
    last_cnt  = 0;
    for (int b = 1; b <= 16; b++) begin
      oresp = mkresp(b == 16, 32'hd000_0000 + 32'(b));
      #1;
      if (iresps_rr[1].ready) ready_cnt++;
      if (iresps_rr[1].last)  last_cnt++;
      check("t1 resp1", 128'(iresps_rr[1]), 128'(oresp));
      check("t1 resp0", 128'(iresps_rr[0]), 128'(0));
      tick();
    end
    oresp = '0;
    ireqs = '0;
    #1;
    check("t1 ready cnt", 128'(ready_cnt), 128'(16));
    check("t1 last cnt",  128'(last_cnt),  128'(1));
    check("t1 end busy",  128'(busy_rr),   128'(0));
    check("t1 end oreq",  128'(oreq_rr),   128'(0));

    // ---- 2: contention with round-robin ----
    do_reset();
    ireqs[0] = mkreq(1'b0, 32'h0000_1000, MLEN8, 32'h0);
    ireqs[1] = mkreq(1'b1, 32'h2000_0000, MLEN8, 32'hcafe_f00d);
    #1;
    check("t2 c0 busy", 128'(busy_rr), 128'(0));
    tick();
    check("t2 g1 idx",  128'(gidx_rr), 128'(0));
    check("t2 g1 oreq", 128'(oreq_rr), 128'(ireqs[0]));
    oresp = mkresp(1'b1, 32'h1111_1111);
    #1;
    check("t2 g1 resp0", 128'(iresps_rr[0]), 128'(oresp));
    check("t2 g1 resp1", 128'(iresps_rr[1]), 128'(0));
    tick();
    oresp = '0;
    #1;
    check("t2 gap busy", 128'(busy_rr), 128'(0));
    check("t2 gap oreq", 128'(oreq_rr), 128'(0));
    tick();
    check("t2 g2 idx",  128'(gidx_rr), 128'(1));
    check("t2 g2 oreq", 128'(oreq_rr), 128'(ireqs[1]));
    oresp = mkresp(1'b1, 32'h2222_2222);
    tick();
    oresp = '0;
    tick();
    check("t2 g3 idx",  128'(gidx_rr), 128'(0));
    check("t2 g3 busy", 128'(busy_rr), 128'(1));

    // ---- 3: fixed priority starves master 1 ----
    do_reset();
    ireqs[0] = mkreq(1'b0, 32'h0000_2000, MLEN4, 32'h0);
    ireqs[1] = mkreq(1'b0, 32'h3000_0000, MLEN4, 32'h0);
    for (int r = 0; r < 3; r++) begin
      tick();
      check("t3 fp busy",  128'(busy_fp),      128'(1));
      check("t3 fp gidx",  128'(gidx_fp),      128'(0));
      oresp = mkresp(1'b1, 32'h3333_0000 + 32'(r));
      #1;
      check("t3 fp resp1", 128'(iresps_fp[1]), 128'(0));
      tick();
      oresp = '0;
      #1;
      check("t3 fp idle",  128'(busy_fp),      128'(0));
    end

    // ---- 4: non-granted master sees nothing ----
    do_reset();
    ireqs[1] = mkreq(1'b1, 32'h4000_0080, MLEN4, 32'hdead_beef);
    tick();
    check("t4 gidx", 128'(gidx_rr), 128'(1));
    ireqs[0] = mkreq(1'b0, 32'h0000_3000, MLEN8, 32'h0);
    for (int b = 0; b < 3; b++) begin
      oresp = mkresp(1'b0, 32'h4444_0000 + 32'(b));
      #1;
      check("t4 resp0",  128'(iresps_rr[0]),       128'(0));
      check("t4 ready1", 128'(iresps_rr[1].ready), 128'(1));
      check("t4 oreq",   128'(oreq_rr),            128'(ireqs[1]));
      tick();
    end
    oresp = mkresp(1'b1, 32'h4444_ffff);
    #1;
    check("t4 last resp0", 128'(iresps_rr[0]), 128'(0));
    tick();
    oresp = '0;
    #1;
    check("t4 end busy", 128'(busy_rr), 128'(0));

    // ---- 5: reset mid-burst ----
    do_reset();
    ireqs[1] = mkreq(1'b0, 32'h5000_0000, MLEN16, 32'h0);
    tick();
    for (int b = 1; b <= 4; b++) begin
      oresp = mkresp(1'b0, 32'h5555_0000 + 32'(b));
      tick();
    end
    oresp = mkresp(1'b0, 32'h5555_0005);
    reset = 1'b1;
    #1;
    check("t5 beat5 ready", 128'(iresps_rr[1].ready), 128'(1));
    tick();
    reset = 1'b0;
    oresp = '0;
    #1;
    check("t5 busy",   128'(busy_rr),   128'(0));
    check("t5 oreq",   128'(oreq_rr),   128'(0));
    check("t5 iresps", 128'(iresps_rr), 128'(0));
    check("t5 gidx",   128'(gidx_rr),   128'(0));
    tick();
    check("t5 rearb busy", 128'(busy_rr), 128'(1));
    check("t5 rearb gidx", 128'(gidx_rr), 128'(1));

    // ---- 6: stray ready/last in IDLE ----
    do_reset();
    oresp = mkresp(1'b1, 32'h6666_6666);
    #1;
    check("t6 iresps now", 128'(iresps_rr), 128'(0));
    tick();
    check("t6 busy",       128'(busy_rr),   128'(0));
    check("t6 iresps",     128'(iresps_rr), 128'(0));
    tick();
    check("t6 busy2",      128'(busy_rr),   128'(0));
    check("t6 gidx",       128'(gidx_rr),   128'(0));
    check("t6 fp iresps",  128'(iresps_fp), 128'(0));
    oresp = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
